// File: rtl/ifetch_queue_stage.sv
// ifetch_queue_stage
//   Instruction-fetch stage with a decoupled imem interface and a fetch buffer.
//   Sequential PCs are issued to imem with up to MAX_OUTSTANDING requests in
//   flight. In-order responses are paired with their issued PC and queued in a
//   FIFO_DEPTH-entry buffer that feeds decode over a valid/ready handshake.
//   A redirect empties the buffer, marks every in-flight response for
//   discard and restarts fetch at the (word-aligned) target.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   imem_req_v_o        request valid
//   imem_req_ready_i    imem accepts the request this cycle
//   imem_addr_o         request address (current fetch PC)
//   imem_resp_v_i       response valid, responses return in request order
//   imem_data_i         response instruction word
//   ir_v_o              buffered instruction available to decode
//   ir_ready_i          decode accepts the head instruction
//   ir_o, pc_o          head instruction and its PC (0 when buffer empty)
//   br_v_i, br_tgt_i    redirect request and target (bits [1:0] ignored)
module ifetch_queue_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_v_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_resp_v_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic            ir_v_o,
    input  logic            ir_ready_i,
    output logic [XLEN-1:0] ir_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            br_v_i,
    input  logic [XLEN-1:0] br_tgt_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

    // Fetch PC and issued-PC tag queue (one tag per in-flight request)
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wr_q;
    logic [TW-1:0]   tag_rd_q;

    // In-flight request count and number of responses still to be discarded
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   drop_q;

    // Fetch buffer
    logic [XLEN-1:0] f_pc_mem [FIFO_DEPTH];
    logic [XLEN-1:0] f_ir_mem [FIFO_DEPTH];
    logic [AW-1:0]   f_wr_q;
    logic [AW-1:0]   f_rd_q;
    logic [CW-1:0]   fcnt_q;

    logic            issue_ok;
    logic            issue;
    logic            resp;
    logic            push;
    logic            pop;
    logic [CW-1:0]   out_after_resp;
    logic [CW:0]     credit_sum;
    logic            unused_tgt_bits;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TW'(1);
    endfunction

    // Credit check counts in-flight requests against free buffer slots, so
    // every response is guaranteed a slot and the buffer cannot overflow.
    assign credit_sum     = {1'b0, out_q} + {1'b0, fcnt_q};
    assign issue_ok       = !br_v_i && (out_q < MAX_OUT) && (credit_sum < DEPTH_SUM);
    assign imem_req_v_o   = !rst_i && issue_ok;
    assign issue          = imem_req_v_o && imem_req_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored
    assign resp           = imem_resp_v_i && (out_q != '0);
    assign push           = resp && (drop_q == '0) && !br_v_i;
    assign pop            = ir_v_o && ir_ready_i;
    assign out_after_resp = out_q - CW'(resp);

    assign imem_addr_o    = pc_q;
    assign ir_v_o         = (fcnt_q != '0);
    assign ir_o           = ir_v_o ? f_ir_mem[f_rd_q] : '0;
    assign pc_o           = ir_v_o ? f_pc_mem[f_rd_q] : '0;

    assign unused_tgt_bits = ^br_tgt_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            f_wr_q   <= '0;
            f_rd_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            out_q <= out_after_resp + CW'(issue);
            if (issue) begin
                tag_wr_q <= tag_inc(tag_wr_q);
            end
            if (resp) begin
                tag_rd_q <= tag_inc(tag_rd_q);
            end
            if (br_v_i) begin
                // Everything still in flight after this cycle's response
                // belongs to the old stream; a same-cycle response is already
                // excluded from out_after_resp and never pushed.
                pc_q   <= {br_tgt_i[XLEN-1:2], 2'b00};
                drop_q <= out_after_resp;
                f_wr_q <= '0;
                f_rd_q <= '0;
                fcnt_q <= '0;
            end else begin
                if (issue) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                if (resp && (drop_q != '0)) begin
                    drop_q <= drop_q - CW'(1);
                end
                if (push) begin
                    f_wr_q <= f_wr_q + AW'(1);
                end
                if (pop) begin
                    f_rd_q <= f_rd_q + AW'(1);
                end
                fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays need no reset: contents are only observed through
    // occupancy-qualified outputs.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push) begin
            f_pc_mem[f_wr_q] <= tag_mem[tag_rd_q];
            f_ir_mem[f_wr_q] <= imem_data_i;
        end
    end

endmodule

// File: tb/tb_ifetch_queue_stage.sv
// tb_ifetch_queue_stage
//   Randomised bench for ifetch_queue_stage. The reference keeps a queue of
//   in-flight fetches (each tagged stale once a redirect passes it) and a
//   queue of buffered instructions; expected outputs come from those queues.
//   The bench also acts as the instruction memory.
module tb_ifetch_queue_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk_i;
    logic        rst_i;
    logic        imem_req_v_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_resp_v_i;
    logic [31:0] imem_data_i;
    logic        ir_v_o;
    logic        ir_ready_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        br_v_i;
    logic [31:0] br_tgt_i;

    ifetch_queue_stage #(
        .XLEN            (32),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_v_o     (imem_req_v_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_resp_v_i    (imem_resp_v_i),
        .imem_data_i      (imem_data_i),
        .ir_v_o           (ir_v_o),
        .ir_ready_i       (ir_ready_i),
        .ir_o             (ir_o),
        .pc_o             (pc_o),
        .br_v_i           (br_v_i),
        .br_tgt_i         (br_tgt_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    fl_t         inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] exp_pc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[11:0], a[31:12]} ^ 32'h6b2f_91c3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_v", {31'b0, imem_req_v_o}, 32'd0);
        chk("rst_ir_v",  {31'b0, ir_v_o},       32'd0);
        chk("rst_ir",    ir_o,                  32'd0);
        chk("rst_pc",    pc_o,                  32'd0);
        chk("rst_addr",  imem_addr_o,           RPC);
    endtask

    // Reset asserted mid-cycle (asynchronously); imem is reset alongside.
    task automatic do_reset();
        @(posedge clk_i);
        #3;
        rst_i            = 1'b1;
        imem_req_ready_i = 1'b1;
        imem_resp_v_i    = 1'b0;
        imem_data_i      = '0;
        ir_ready_i       = 1'b1;
        br_v_i           = 1'b0;
        br_tgt_i         = '0;
        inflight.delete();
        fifo_m.delete();
        exp_pc = RPC;
        #1;
        check_reset_outputs();
        @(posedge clk_i);
        #1;
        check_reset_outputs();
        @(negedge clk_i);
        rst_i            = 1'b0;
        imem_req_ready_i = 1'b0;
        ir_ready_i       = 1'b0;
    endtask

    task automatic do_cycle(input bit rdy, input bit irr, input bit br,
                            input logic [31:0] tgt, input int lat);
        bit   resp;
        bit   exp_req;
        bit   pop;
        bit   have_push;
        ent_t e;
        fl_t  f;

        @(negedge clk_i);
        resp             = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_req_ready_i = rdy;
        ir_ready_i       = irr;
        br_v_i           = br;
        br_tgt_i         = tgt;
        imem_resp_v_i    = resp;
        imem_data_i      = resp ? mem_word(inflight[0].addr) : $urandom();
        #1;

        exp_req = !br && (inflight.size() < MAXO) && ((inflight.size() + fifo_m.size()) < DEPTH);
        chk("req_v", {31'b0, imem_req_v_o}, {31'b0, exp_req});
        chk("addr",  imem_addr_o, exp_pc);
        chk("ir_v",  {31'b0, ir_v_o}, {31'b0, fifo_m.size() != 0});
        chk("ir",    ir_o, (fifo_m.size() != 0) ? fifo_m[0].data : 32'd0);
        chk("pc",    pc_o, (fifo_m.size() != 0) ? fifo_m[0].pc   : 32'd0);

        pop       = (fifo_m.size() != 0) && irr;
        have_push = 1'b0;
        if (resp) begin
            f = inflight.pop_front();
            if (!f.stale && !br) begin
                have_push = 1'b1;
                e.pc   = f.addr;
                e.data = mem_word(f.addr);
            end
        end
        if (br) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            exp_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(fifo_m.pop_front());
            if (have_push) fifo_m.push_back(e);
            if (exp_req && rdy) begin
                f.addr  = exp_pc;
                f.stale = 1'b0;
                f.due   = cyc + lat;
                inflight.push_back(f);
                exp_pc = exp_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        rst_i            = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_resp_v_i    = 1'b0;
        imem_data_i      = '0;
        ir_ready_i       = 1'b0;
        br_v_i           = 1'b0;
        br_tgt_i         = '0;
        exp_pc           = RPC;
        do_reset();

        // Streaming, 1-cycle memory
        repeat (12) do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);

        // Decode stall fills the buffer, single pop frees one credit
        repeat (8) do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1);
        do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        repeat (5) do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1);
        repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);

        // 3-cycle memory, redirect to an unaligned target mid-stream
        for (int i = 0; i < 24; i++)
            do_cycle(1'b1, (i % 3) != 0, i == 12, 32'h2002, 3);
        repeat (12) do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);

        // Redirect coinciding with response and pop, then back-to-back
        for (int i = 0; i < 16; i++)
            do_cycle(1'b1, 1'b1, (i == 8) || (i == 9), 32'h3000 + 32'(i * 16), 1);

        do_reset();

        // PC wrap with randomly stalled imem
        do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFEE, 1);
        repeat (40) do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, 32'd0, 2);

        // Fully random traffic with occasional redirects
        repeat (400) begin
            do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                     $urandom_range(0, 15) == 0, $urandom(), $urandom_range(1, 4));
        end
        repeat (20) do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
